// File: rtl/delay_sequencer.sv
// Job sequencer for a downstream delay block: queues requested delays, runs them one at a
// time with a registered start pulse window, and tracks completions, latency and timeouts.
module delay_sequencer #(
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_delay,
  output logic        req_ready,
  output logic        start,
  output logic [31:0] delay_in,
  input  logic [31:0] done,
  input  logic        clr_err,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] done_count,
  output logic [31:0] last_latency
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t        state, next_state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   run_cnt;
  logic [GW-1:0] gap_cnt;
  logic          push, pop, job_done, job_timeout, gap_last;

  assign req_ready   = (count < FULL);
  assign push        = req_valid && req_ready;
  assign job_done    = (state == RUN) && (done == 32'hFFFF_FFFF);
  assign job_timeout = (state == RUN) && !job_done && (TIMEOUT != 0) && (run_cnt == 32'(TIMEOUT));
  assign gap_last    = (state == GAP) && (gap_cnt == GW'(GAP_CYCLES - 1));
  // The last GAP cycle doubles as the IDLE decision so queued jobs see exactly GAP_CYCLES low cycles.
  assign pop         = (count != '0) && ((state == IDLE) || gap_last);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_delay;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (count != '0) next_state = RUN;
      RUN:     if (job_done || job_timeout) next_state = GAP;
      GAP:     if (gap_last) next_state = (count != '0) ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // start is a flop so nothing on done or req_* reaches the delay block combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      start    <= 1'b0;
      delay_in <= '0;
      run_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= next_state;
      start <= (next_state == RUN);
      if (pop) begin
        delay_in <= mem[rd_ptr];
        run_cnt  <= 32'd1;
      end else if ((state == RUN) && (run_cnt != 32'hFFFF_FFFF)) begin
        run_cnt <= run_cnt + 32'd1;
      end
      if ((state == GAP) && !gap_last) gap_cnt <= gap_cnt + 1'b1;
      else                             gap_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err  <= 1'b0;
      done_count   <= '0;
      last_latency <= '0;
    end else begin
      if (job_done) begin
        last_latency <= run_cnt;
        done_count   <= done_count + 16'd1;
      end
      if (job_timeout)  timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delay_sequencer.sv
// Scoreboard bench for delay_sequencer: one instance with the long default timeout for
// completion tests and one with a 16-cycle timeout, each driven by a small delay-block model.
module tb_delay_sequencer;

  localparam int GAP       = 1;
  localparam int TMO_LONG  = 1024;
  localparam int TMO_SHORT = 16;

  logic        clk, rst;
  logic        req_valid    [2];
  logic [31:0] req_delay    [2];
  logic        req_ready    [2];
  logic        start        [2];
  logic [31:0] delay_in     [2];
  logic [31:0] done         [2];
  logic        clr_err      [2];
  logic        busy         [2];
  logic        timeout_err  [2];
  logic [15:0] done_count   [2];
  logic [31:0] last_latency [2];

  int          check_cnt, pass_cnt;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  int          tmo [2];
  int          done_mode [2];
  logic [31:0] done_idle [2];
  int          run_len [2], low_len [2], last_run_len [2];
  bit          prev_start [2], done_fired [2], to_fired [2], queued_at_end [2], had_run [2];
  bit          clr_at_to [2], clr_drop [2];
  logic [31:0] cur_delay [2], exp_lat [2];
  logic [15:0] exp_cnt [2];
  logic        exp_terr [2];

  delay_sequencer #(.DEPTH(4), .TIMEOUT(TMO_LONG), .GAP_CYCLES(GAP)) dut_main (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_delay(req_delay[0]),
    .req_ready(req_ready[0]), .start(start[0]), .delay_in(delay_in[0]), .done(done[0]),
    .clr_err(clr_err[0]), .busy(busy[0]), .timeout_err(timeout_err[0]),
    .done_count(done_count[0]), .last_latency(last_latency[0])
  );

  delay_sequencer #(.DEPTH(4), .TIMEOUT(TMO_SHORT), .GAP_CYCLES(GAP)) dut_tmo (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_delay(req_delay[1]),
    .req_ready(req_ready[1]), .start(start[1]), .delay_in(delay_in[1]), .done(done[1]),
    .clr_err(clr_err[1]), .busy(busy[1]), .timeout_err(timeout_err[1]),
    .done_count(done_count[1]), .last_latency(last_latency[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) $display("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    else pass_cnt++;
  endtask

  function automatic int qSize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic qPush(input int i, input logic [31:0] v);
    if (i == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic qPop(input int i, output logic [31:0] v);
    if (i == 0) v = exp_q0.pop_front();
    else        v = exp_q1.pop_front();
  endtask

  task automatic resetModel(input int i);
    prev_start[i] = 1'b0; run_len[i] = 0; low_len[i] = 0;
    done_fired[i] = 1'b0; to_fired[i] = 1'b0; queued_at_end[i] = 1'b0; had_run[i] = 1'b0;
    exp_cnt[i] = '0; exp_lat[i] = '0; exp_terr[i] = 1'b0;
  endtask

  task automatic checkReset(input int i);
    checkOutput($sformatf("rst_start[%0d]", i),        32'(start[i]),       32'd0);
    checkOutput($sformatf("rst_delay_in[%0d]", i),     delay_in[i],         32'd0);
    checkOutput($sformatf("rst_req_ready[%0d]", i),    32'(req_ready[i]),   32'd1);
    checkOutput($sformatf("rst_busy[%0d]", i),         32'(busy[i]),        32'd0);
    checkOutput($sformatf("rst_timeout_err[%0d]", i),  32'(timeout_err[i]), 32'd0);
    checkOutput($sformatf("rst_done_count[%0d]", i),   32'(done_count[i]),  32'd0);
    checkOutput($sformatf("rst_last_latency[%0d]", i), last_latency[i],     32'd0);
  endtask

  // One push attempt; accept states whether the FIFO should take it.
  task automatic applyStimulus(input int i, input logic [31:0] value, input bit accept);
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_delay[i] = value;
    checkOutput($sformatf("req_ready[%0d]", i), 32'(req_ready[i]), 32'(accept));
    if (accept) qPush(i, value);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic waitIdle(input int i);
    bit ok = 1'b0;
    for (int n = 0; n < 600 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (qSize(i) == 0 && !busy[i] && !start[i]) ok = 1'b1;
    end
    checkOutput($sformatf("idle_reached[%0d]", i), 32'(ok), 32'd1);
  endtask

  // Delay-block model and scoreboard: drives done, pops expected jobs as RUN windows open.
  task automatic monitorOutputs();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (clr_drop[i]) begin
          clr_err[i]  = 1'b0;
          clr_drop[i] = 1'b0;
        end
        if (rst) begin
          prev_start[i] = 1'b0; run_len[i] = 0; low_len[i] = 0;
          done_fired[i] = 1'b0; to_fired[i] = 1'b0; queued_at_end[i] = 1'b0; had_run[i] = 1'b0;
          done[i] = done_idle[i];
        end else if (start[i]) begin
          if (!prev_start[i]) begin
            if (qSize(i) == 0) begin
              checkOutput($sformatf("unexpected_start[%0d]", i), 32'(start[i]), 32'd0);
            end else begin
              qPop(i, cur_delay[i]);
              if (queued_at_end[i])
                checkOutput($sformatf("gap_len[%0d]", i), 32'(low_len[i]), 32'(GAP));
            end
            run_len[i] = 0; queued_at_end[i] = 1'b0; had_run[i] = 1'b0;
          end else if (done_fired[i] || to_fired[i]) begin
            checkOutput($sformatf("run_overrun[%0d]", i), 32'(start[i]), 32'd0);
          end
          run_len[i]++;
          checkOutput($sformatf("delay_in[%0d]", i), delay_in[i], cur_delay[i]);
          if (done_mode[i] == 0 && 32'(run_len[i]) >= cur_delay[i]) begin
            done[i] = 32'hFFFF_FFFF;
            done_fired[i] = 1'b1;
            exp_cnt[i]++;
            exp_lat[i] = 32'(run_len[i]);
          end else begin
            done[i] = done_idle[i];
            if (tmo[i] != 0 && run_len[i] == tmo[i]) begin
              to_fired[i] = 1'b1;
              exp_terr[i] = 1'b1;
              if (clr_at_to[i]) begin
                clr_err[i] = 1'b1; clr_at_to[i] = 1'b0; clr_drop[i] = 1'b1;
              end
            end
          end
        end else begin
          done[i] = done_idle[i];
          if (prev_start[i]) begin
            checkOutput($sformatf("run_end_cause[%0d]", i), 32'(done_fired[i] | to_fired[i]), 32'd1);
            checkOutput($sformatf("done_count[%0d]", i), 32'(done_count[i]), 32'(exp_cnt[i]));
            checkOutput($sformatf("last_latency[%0d]", i), last_latency[i], exp_lat[i]);
            checkOutput($sformatf("timeout_err[%0d]", i), 32'(timeout_err[i]), 32'(exp_terr[i]));
            checkOutput($sformatf("gap_busy[%0d]", i), 32'(busy[i]), 32'd1);
            last_run_len[i] = run_len[i];
            queued_at_end[i] = (qSize(i) > 0);
            had_run[i] = 1'b1; low_len[i] = 1;
            done_fired[i] = 1'b0; to_fired[i] = 1'b0;
          end else begin
            low_len[i]++;
            if (had_run[i] && !queued_at_end[i] && low_len[i] == GAP + 1)
              checkOutput($sformatf("idle_after_gap[%0d]", i), 32'(busy[i]), 32'd0);
          end
        end
        prev_start[i] = start[i];
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit reached;
    check_cnt = 0; pass_cnt = 0;
    rst = 1'b1;
    tmo[0] = TMO_LONG; tmo[1] = TMO_SHORT;
    done_idle[0] = 32'hFFFF_0000; done_idle[1] = 32'h0000_FFFF;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_delay[i] = '0; clr_err[i] = 1'b0;
      done[i] = done_idle[i]; done_mode[i] = 0; last_run_len[i] = 0;
      clr_at_to[i] = 1'b0; clr_drop[i] = 1'b0; cur_delay[i] = '0;
      resetModel(i);
    end
    fork
      monitorOutputs();
    join_none

    repeat (2) @(negedge clk);
    checkReset(0);
    checkReset(1);

    // Single job, pushed in the same instant reset is released.
    #2;
    rst = 1'b0;
    req_valid[0] = 1'b1; req_delay[0] = 32'd10; qPush(0, 32'd10);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    waitIdle(0);
    checkOutput("single_start_cycles", 32'(last_run_len[0]), 32'd10);
    checkOutput("single_latency", last_latency[0], 32'd10);
    checkOutput("single_count", 32'(done_count[0]), 32'd1);

    // Back-to-back jobs.
    applyStimulus(0, 32'd10, 1'b1);
    applyStimulus(0, 32'd50, 1'b1);
    waitIdle(0);
    checkOutput("b2b_latency", last_latency[0], 32'd50);
    checkOutput("b2b_count", 32'(done_count[0]), 32'd3);

    // Full FIFO with a stalled delay block, then release.
    done_mode[0] = 1;
    for (int k = 0; k < 5; k++) applyStimulus(0, 32'(3 + k), 1'b1);
    applyStimulus(0, 32'd99, 1'b0);
    @(negedge clk);
    checkOutput("full_ready", 32'(req_ready[0]), 32'd0);
    checkOutput("full_busy", 32'(busy[0]), 32'd1);
    done_mode[0] = 0;
    waitIdle(0);
    checkOutput("full_count", 32'(done_count[0]), 32'd8);
    checkOutput("full_latency", last_latency[0], 32'd7);

    // Timeout with a partial done pattern, zero delay passed through.
    done_mode[1] = 1;
    applyStimulus(1, 32'd0, 1'b1);
    waitIdle(1);
    checkOutput("tmo_flag", 32'(timeout_err[1]), 32'd1);
    checkOutput("tmo_run_len", 32'(last_run_len[1]), 32'd16);
    checkOutput("tmo_count", 32'(done_count[1]), 32'd0);
    checkOutput("tmo_latency", last_latency[1], 32'd0);
    @(negedge clk);
    clr_err[1] = 1'b1;
    @(negedge clk);
    clr_err[1] = 1'b0;
    exp_terr[1] = 1'b0;
    checkOutput("clr_clears", 32'(timeout_err[1]), 32'd0);
    clr_at_to[1] = 1'b1;
    applyStimulus(1, 32'd20, 1'b1);
    applyStimulus(1, 32'd21, 1'b1);
    waitIdle(1);
    checkOutput("clr_coincident_used", 32'(clr_at_to[1]), 32'd0);
    checkOutput("set_wins", 32'(timeout_err[1]), 32'd1);
    checkOutput("tmo_count_after", 32'(done_count[1]), 32'd0);

    // Reset on RUN cycle 5 with three jobs queued.
    done_mode[0] = 1;
    for (int k = 0; k < 4; k++) applyStimulus(0, 32'(100 + k), 1'b1);
    reached = 1'b0;
    for (int n = 0; n < 50 && !reached; n++) begin
      @(negedge clk);
      #1;
      if (run_len[0] >= 5) reached = 1'b1;
    end
    checkOutput("reached_run5", 32'(run_len[0]), 32'd5);
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    resetModel(0);
    resetModel(1);
    #1;
    checkReset(0);
    checkReset(1);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("no_resume_start", 32'(start[0]), 32'd0);
    checkOutput("no_resume_busy", 32'(busy[0]), 32'd0);
    checkOutput("no_resume_count", 32'(done_count[0]), 32'd0);

    done_mode[0] = 0;
    applyStimulus(0, 32'd4, 1'b1);
    waitIdle(0);
    checkOutput("post_reset_count", 32'(done_count[0]), 32'd1);
    checkOutput("post_reset_latency", last_latency[0], 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/delay_sequencer.md
DELAY_SEQUENCER -- requirements
Module: delay_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of request FIFO entries (power of 2, >=2).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, the maximum number of RUN cycles per job; 0 disables the timeout.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 1, the number of start-low cycles between jobs (>=1).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  request-delay push strobe.
REQ-007 req_delay  input  32  delay value for the queued job.
REQ-008 req_ready  output  1  FIFO can accept a push this cycle.
REQ-009 start  output  1  drives the delay block's start input.
REQ-010 delay_in  output  32  drives the delay block's delay_in input.
REQ-011 done  input  32  delay block's done bus; a job completes only when it equals 32'hFFFFFFFF.
REQ-012 clr_err  input  1  synchronous clear of timeout_err.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 timeout_err  output  1  sticky flag: a job hit TIMEOUT.
REQ-015 done_count  output  16  completed-job counter.
REQ-016 last_latency  output  32  RUN-cycle count of the most recently completed job.

Function
REQ-017 A push SHALL occur exactly when req_valid & req_ready; req_ready SHALL be high iff FIFO occupancy < DEPTH. A push while the FIFO is full is dropped, including when a pop happens in the same cycle.
REQ-018 The FIFO SHALL be first-in first-out, with wrapping read/write pointers and an occupancy counter of width clog2(DEPTH)+1; a push and pop in the same cycle leave occupancy unchanged.
REQ-019 The FSM SHALL have states IDLE, RUN, GAP.
REQ-020 IDLE: if the FIFO is non-empty, pop the head into the delay_in register and go to RUN next cycle. Otherwise stay in IDLE.
REQ-021 RUN: start SHALL be 1, and delay_in SHALL be held stable for the whole RUN.
REQ-022 RUN: run_cnt SHALL start at 1 on the first RUN cycle and increment each RUN cycle, saturating at 32'hFFFFFFFF.
REQ-023 RUN, done==32'hFFFFFFFF sampled: last_latency <= run_cnt; done_count increments (wrapping 16'hFFFF->0); go to GAP.
REQ-024 RUN, no done and TIMEOUT!=0 and run_cnt==TIMEOUT: set timeout_err; done_count and last_latency are unchanged; go to GAP.
REQ-025 Any done value other than all-ones SHALL be ignored in every state; done is also ignored in IDLE and GAP.
REQ-026 GAP: start SHALL be 0 for exactly GAP_CYCLES cycles, then the FSM goes to IDLE. A queued job therefore restarts GAP_CYCLES+1 cycles after completion.
REQ-027 start SHALL be registered, with no combinational path from done or req_* to start.
REQ-028 req_delay==0 SHALL be passed through unmodified with no special case.
REQ-029 If clr_err and a timeout occur in the same cycle, set SHALL win.
REQ-030 delay_in SHALL keep the last job's value outside RUN.

Reset
REQ-031 While rst is high, and asynchronously on its assertion: state=IDLE, start=0, delay_in=0, FIFO empty (req_ready=1), busy=0, timeout_err=0, done_count=0, last_latency=0, run_cnt=0.
REQ-032 rst asserted mid-RUN SHALL drop start immediately and discard the active job and all queued jobs; no completion is counted.
REQ-033 After rst deasserts, the first push SHALL be accepted on the next rising edge.

Verification
REQ-034 Single job: push 10; bench model asserts done=all-ones on the 10th start-high cycle -> start high exactly 10 cycles, last_latency=10, done_count=1, start low 1 cycle (GAP), then IDLE.
REQ-035 Back-to-back jobs: push 10 then 50 in consecutive cycles -> two RUN windows with delay_in 10 then 50, separated by exactly GAP_CYCLES start-low cycles; done_count=2, last_latency=50.
REQ-036 Full FIFO: with the model never asserting done, push 5 values (DEPTH=4) -> 1 job in RUN and 4 queued, req_ready=0, and a 6th push dropped; FIFO order is verified on release.
REQ-037 Timeout: TIMEOUT=16, done held at 32'h0000FFFF -> timeout_err=1 after RUN cycle 16, done_count unchanged, next job starts. clr_err clears the flag; clr_err coincident with a new timeout leaves it set.
REQ-038 Reset mid-run: rst pulsed on RUN cycle 5 with 3 jobs queued -> start=0 asynchronously, all outputs at reset values, req_ready=1, no job resumes.
